// File: rtl/button_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_reader_pkg
// Description : Shared definitions for the button_reader peripheral:
//               register indices, PEND/CTRL bit positions, debouncer
//               state encoding and a small read-data helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package button_reader_pkg;

  // Word register indices on the 2-bit address bus
  localparam logic [1:0] BR_STATUS = 2'd0;
  localparam logic [1:0] BR_PEND   = 2'd1;
  localparam logic [1:0] BR_CTRL   = 2'd2;
  localparam logic [1:0] BR_RSVD   = 2'd3;

  // Bit positions inside PEND and CTRL
  localparam int BR_RISE = 0;
  localparam int BR_FALL = 1;

  // Debouncer state: IDLE while the synchronised pin agrees with the
  // debounced level, COUNT while it disagrees.
  typedef enum logic [0:0] {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_t;

  // Zero-extend a 2-bit register field onto the 32-bit read bus
  function automatic logic [31:0] br_zext2(input logic [1:0] v);
    return {30'd0, v};
  endfunction

endpackage : button_reader_pkg
`default_nettype wire

// File: rtl/button_reader_debounce.sv
`default_nettype none
// ============================================================================
// Module      : debounce
// Description : Two-flop synchroniser followed by a counting debouncer.
//               The debounced level only changes after DEBOUNCE_CYCLES
//               consecutive synchronised samples disagree with it.
// Parameters  : DEBOUNCE_CYCLES - stable samples needed (2..65536)
// Ports       : clk        in  system clock
//               reset_n    in  asynchronous active-low reset
//               btn_raw    in  raw pin, asynchronous to clk
//               level      out debounced level (registered)
//               rise_pulse out high in the cycle level is about to go 0->1
//               fall_pulse out high in the cycle level is about to go 1->0
// Revision    : 1.0 - initial release
// ============================================================================
module debounce
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;
  db_state_t        state;
  logic             at_limit;

  // Synchroniser chain; sync_meta may go metastable and is never used
  // anywhere else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // The state is fully defined by whether sync disagrees with level, so it
  // is decoded rather than stored: a bounce back to level drops straight to
  // IDLE in the same cycle, which is what clears the counter.
  assign state    = (sync != level) ? DB_COUNT : DB_IDLE;
  assign at_limit = (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        DB_IDLE: begin
          cnt <= '0;
        end
        DB_COUNT: begin
          if (at_limit) begin
            level <= ~level;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Edge strobes are combinational so the register file can set PEND on the
  // very edge that toggles level.
  assign rise_pulse = (state == DB_COUNT) && at_limit && !level;
  assign fall_pulse = (state == DB_COUNT) && at_limit &&  level;

endmodule : debounce
`default_nettype wire

// File: rtl/button_reader.sv
`default_nettype none
// ============================================================================
// Module      : button_reader
// Description : Memory-mapped push-button reader. Debounces a raw pin,
//               keeps sticky rise/fall flags (PEND, write-1-to-clear) and
//               optionally raises a level interrupt.
//               Build option: define BUTTON_READER_IRQ_EN to implement the
//               CTRL register and drive irq; otherwise CTRL reads 0 and irq
//               is tied low.
// Parameters  : DEBOUNCE_CYCLES - stable samples needed (2..65536)
// Ports       : clk      in  system clock
//               reset_n  in  asynchronous active-low reset
//               btn_raw  in  raw button pin
//               sel      in  bus access request, held until ready
//               we       in  1 = write, 0 = read
//               addr     in  [1:0]  word register index
//               wdata    in  [31:0] write data
//               rdata    out [31:0] read data, valid while ready = 1
//               ready    out single-cycle access acknowledge
//               irq      out level interrupt request
// Registers   : 0 STATUS RO  bit0 level
//               1 PEND   W1C bit0 RISE, bit1 FALL
//               2 CTRL   RW  bit0 RISE_IE, bit1 FALL_IE
//               3 reserved, reads 0
// Revision    : 1.0 - initial release
// ============================================================================
module button_reader
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_raw,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq
);

  logic        level;
  logic        rise_pulse;
  logic        fall_pulse;
  logic        access;
  logic        wr_en;
  logic [1:0]  pend;
  logic [1:0]  pend_set;
  logic [1:0]  pend_clr;
  logic [1:0]  ctrl;
  logic [31:0] rd_word;
  logic        unused_wdata;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .level     (level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  // An access is accepted only while ready is low, so a held sel cannot be
  // acknowledged twice in a row.
  assign access = sel && !ready;
  assign wr_en  = access && we;

  // ---------------------------------------------------------------------------
  // PEND: sticky edge flags. Set is OR-ed after the clear so a new edge on
  // the same edge as a W1C write survives.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_set          = 2'b00;
    pend_set[BR_RISE] = rise_pulse;
    pend_set[BR_FALL] = fall_pulse;
  end

  assign pend_clr = (wr_en && (addr == BR_PEND)) ? wdata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= 2'b00;
    end else begin
      pend <= (pend & ~pend_clr) | pend_set;
    end
  end

  // ---------------------------------------------------------------------------
  // CTRL and interrupt
  // ---------------------------------------------------------------------------
`ifdef BUTTON_READER_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl <= 2'b00;
      irq  <= 1'b0;
    end else begin
      if (wr_en && (addr == BR_CTRL)) begin
        ctrl <= wdata[1:0];
      end
      irq <= |(pend & ctrl);
    end
  end
`else
  assign ctrl = 2'b00;
  assign irq  = 1'b0;
`endif

  // Only the low two write-data bits map onto any register
  assign unused_wdata = &{1'b0, wdata[31:2]};

  // ---------------------------------------------------------------------------
  // Read mux and bus response
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = 32'd0;
    case (addr)
      BR_STATUS: rd_word[0] = level;
      BR_PEND:   rd_word    = br_zext2(pend);
      BR_CTRL:   rd_word    = br_zext2(ctrl);
      default:   rd_word    = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready <= 1'b0;
      rdata <= 32'd0;
    end else begin
      ready <= access;
      rdata <= access ? rd_word : 32'd0;
    end
  end

endmodule : button_reader
`default_nettype wire

// File: tb/tb_button_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_reader
// Description : Self-checking bench for button_reader with DEBOUNCE_CYCLES=16.
//               Register behaviour is driven from a vector table; debounce
//               latency, glitch rejection, interrupt, W1C/set collision and
//               mid-count reset are hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_reader;
  import button_reader_pkg::*;

  localparam int DB = 16;

`ifdef BUTTON_READER_IRQ_EN
  localparam logic [31:0] CTRL_RB = 32'h3;
  localparam logic        IRQ_ON  = 1'b1;
`else
  localparam logic [31:0] CTRL_RB = 32'h0;
  localparam logic        IRQ_ON  = 1'b0;
`endif

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_raw = 1'b0;
  logic        sel     = 1'b0;
  logic        we      = 1'b0;
  logic [1:0]  addr    = 2'd0;
  logic [31:0] wdata   = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  button_reader #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_raw(btn_raw),
    .sel    (sel),
    .we     (we),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .ready  (ready),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    tick();
    check("rd_ready", {31'd0, ready}, 32'd1);
    d   = rdata;
    sel = 1'b0;
    tick();
  endtask

  task automatic rd_expect(input logic [1:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
    sel = 1'b1; we = 1'b1; addr = a; wdata = data;
    tick();
    check("wr_ready", {31'd0, ready}, 32'd1);
    sel = 1'b0; we = 1'b0;
    tick();
  endtask

  // Drive btn_raw to v and verify level flips on exactly the (DB+2)th edge
  task automatic press_check(input logic v, input string name);
    btn_raw = v;
    for (int i = 1; i <= DB + 2; i++) begin
      tick();
      if (i == DB + 1) check({name, "_early"}, {31'd0, dut.u_debounce.level}, {31'd0, ~v});
      if (i == DB + 2) check({name, "_exact"}, {31'd0, dut.u_debounce.level}, {31'd0, v});
    end
  endtask

  initial begin
    logic [31:0] d;
    int          bad;

    // ---------------- reset sequence ----------------
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_irq",   {31'd0, irq},   32'd0);
    check("rst_rdata", rdata,          32'd0);
    reset_n = 1'b1;
    tick();

    // Held sel: acknowledge, ignored cycle, acknowledge again
    sel = 1'b1; we = 1'b0; addr = BR_STATUS;
    tick(); check("hold_ack1",  {31'd0, ready}, 32'd1);
    tick(); check("hold_gap",   {31'd0, ready}, 32'd0);
    check("hold_gap_rdata", rdata, 32'd0);
    tick(); check("hold_ack2",  {31'd0, ready}, 32'd1);
    sel = 1'b0;
    tick(); check("hold_release", {31'd0, ready}, 32'd0);

    // ---------------- register table ----------------
    vt[0]  = '{1'b0, BR_STATUS, 32'h0,        32'h0,   "status_rst"};
    vt[1]  = '{1'b0, BR_PEND,   32'h0,        32'h0,   "pend_rst"};
    vt[2]  = '{1'b0, BR_CTRL,   32'h0,        32'h0,   "ctrl_rst"};
    vt[3]  = '{1'b0, BR_RSVD,   32'h0,        32'h0,   "rsvd_rst"};
    vt[4]  = '{1'b1, BR_CTRL,   32'hFFFF_FFFF, 32'h0,  "wr_ctrl"};
    vt[5]  = '{1'b0, BR_CTRL,   32'h0,        CTRL_RB, "ctrl_rb"};
    vt[6]  = '{1'b1, BR_STATUS, 32'hFFFF_FFFF, 32'h0,  "wr_status"};
    vt[7]  = '{1'b0, BR_STATUS, 32'h0,        32'h0,   "status_ro"};
    vt[8]  = '{1'b1, BR_RSVD,   32'hFFFF_FFFF, 32'h0,  "wr_rsvd"};
    vt[9]  = '{1'b0, BR_RSVD,   32'h0,        32'h0,   "rsvd_ro"};
    vt[10] = '{1'b1, BR_CTRL,   32'h0,        32'h0,   "wr_ctrl0"};
    vt[11] = '{1'b0, BR_CTRL,   32'h0,        32'h0,   "ctrl_clr"};
    for (int i = 0; i < 12; i++) begin
      if (vt[i].we) bus_write(vt[i].addr, vt[i].wdata);
      else          rd_expect(vt[i].addr, vt[i].exp, vt[i].name);
    end
    check("irq_idle", {31'd0, irq}, 32'd0);

    // ---------------- clean press / release ----------------
    press_check(1'b1, "press");
    rd_expect(BR_PEND,   32'h1, "press_pend");
    rd_expect(BR_STATUS, 32'h1, "press_status");
    press_check(1'b0, "release");
    rd_expect(BR_PEND,   32'h3, "release_pend");
    bus_write(BR_PEND, 32'h3);
    rd_expect(BR_PEND,   32'h0, "pend_w1c");

    // ---------------- glitch ----------------
    bad = 0;
    btn_raw = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) btn_raw = 1'b0;
      tick();
      if (dut.u_debounce.level !== 1'b0) bad++;
    end
    check("glitch_level", bad, 0);
    rd_expect(BR_STATUS, 32'h0, "glitch_status");
    rd_expect(BR_PEND,   32'h0, "glitch_pend");

    // ---------------- interrupt path ----------------
    bus_write(BR_CTRL, 32'h2);
    press_check(1'b1, "irq_press");
    check("irq_rise_masked", {31'd0, irq}, 32'd0);
    btn_raw = 1'b0;
    repeat (DB + 2) tick();
    check("irq_fall_same_edge", {31'd0, irq}, 32'd0);
    tick();
    check("irq_fall_next", {31'd0, irq}, {31'd0, IRQ_ON});
    sel = 1'b1; we = 1'b1; addr = BR_PEND; wdata = 32'h2;
    tick();
    check("irq_clr_edge", {31'd0, irq}, {31'd0, IRQ_ON});
    sel = 1'b0; we = 1'b0;
    tick();
    check("irq_cleared", {31'd0, irq}, 32'd0);
    rd_expect(BR_PEND, 32'h1, "irq_pend_left");
    bus_write(BR_PEND, 32'h3);
    bus_write(BR_CTRL, 32'h0);

    // ---------------- W1C / set collision ----------------
    bus_write(BR_PEND, 32'h1);
    rd_expect(BR_PEND, 32'h0, "w1c_plain");
    btn_raw = 1'b1;
    repeat (DB + 1) tick();
    sel = 1'b1; we = 1'b1; addr = BR_PEND; wdata = 32'h1;
    tick();
    check("coll_level", {31'd0, dut.u_debounce.level}, 32'd1);
    sel = 1'b0; we = 1'b0;
    tick();
    rd_expect(BR_PEND, 32'h1, "coll_pend");

    // Repeated edges with flags already set stay sticky at 1
    press_check(1'b0, "rep_release");
    press_check(1'b1, "rep_press");
    rd_expect(BR_PEND, 32'h3, "rep_pend");
    press_check(1'b0, "rep_release2");
    bus_write(BR_PEND, 32'h3);

    // ---------------- reset mid-count ----------------
    btn_raw = 1'b1;
    repeat (8) tick();
    reset_n = 1'b0;
    #1;
    check("mid_rst_level", {31'd0, dut.u_debounce.level}, 32'd0);
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    repeat (2) tick();
    check("mid_rst_hold", {31'd0, dut.u_debounce.level}, 32'd0);
    reset_n = 1'b1;
    for (int i = 1; i <= DB + 2; i++) begin
      tick();
      if (i == DB + 1) check("mid_rst_early", {31'd0, dut.u_debounce.level}, 32'd0);
      if (i == DB + 2) check("mid_rst_exact", {31'd0, dut.u_debounce.level}, 32'd1);
    end
    rd_expect(BR_PEND, 32'h1, "mid_rst_pend");
    rd_expect(BR_CTRL, 32'h0, "mid_rst_ctrl");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_button_reader
`default_nettype wire

// File: doc/button_reader.md
# button_reader

Memory-mapped input peripheral that turns a raw asynchronous push-button pin into clean, CPU-readable state. It is the SoC-side consumer of the button stimulus the board-level bench drives on `BTN1`. It sits between the `BTN1` pad and the CPU data bus and provides:
- synchronisation and debouncing of the raw pin;
- sticky rise/fall edge flags;
- an optional interrupt request.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1024: consecutive stable synchronised samples required before the debounced level changes; legal range 2..65536.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `btn_raw`  in  1  raw button pin, asynchronous to `clk`
- `sel`  in  1  bus access request; held until `ready`
- `we`  in  1  1 = write, 0 = read
- `addr`  in  2  word register index
- `wdata`  in  32  write data
- `rdata`  out  32  read data, valid while `ready` = 1
- `ready`  out  1  single-cycle access acknowledge
- `irq`  out  1  level interrupt request

## Operation
- Synchroniser: 2-flop chain on `btn_raw` produces `sync`. Both flops reset to 0.
- Debouncer: debounced level `level`, counter `cnt` of width clog2(DEBOUNCE_CYCLES).
  - State IDLE (`sync` == `level`): `cnt` held at 0.
  - State COUNT (`sync` != `level`): `cnt` increments each cycle.
  - A `sync` change back to `level` while in COUNT clears `cnt` and returns to IDLE.
  - When `cnt` == DEBOUNCE_CYCLES-1 with `sync` still != `level`: `level` toggles and `cnt` clears.
- Edge flags: in the cycle `level` toggles, set PEND.RISE (0→1) or PEND.FALL (1→0).
- Registers, selected by `addr`:
  - 0 STATUS, RO: bit0 = `level`.
  - 1 PEND, W1C: bit0 RISE, bit1 FALL.
  - 2 CTRL, RW: bit0 RISE_IE, bit1 FALL_IE.
  - 3: reserved, reads 0.
  - Unused bits read 0. Writes to RO or reserved locations are ignored.
- `irq` = |(PEND[1:0] & CTRL[1:0]), registered.
- Reset values: `level` 0, `cnt` 0, PEND 0, CTRL 0, `rdata` 0, `ready` 0, `irq` 0.

## Timing
- Bus access:
  - `sel` sampled high with `ready` low → `ready` = 1 on the next cycle, for exactly one cycle.
  - `rdata` is registered in the same edge as `ready`; it shows register contents as of the `sel` cycle.
  - Writes take effect on the edge that raises `ready`.
  - No back-to-back acknowledge: `sel` is ignored in the `ready` cycle.
  - `rdata` returns to 0 when `ready` is low.
- Input latency: a clean `btn_raw` transition shows in `level` after 2 + DEBOUNCE_CYCLES rising edges. PEND updates on the same edge; `irq` follows one cycle later.
- Glitch rejection: any `btn_raw` pulse shorter than DEBOUNCE_CYCLES cycles (after synchronisation) never changes `level`.
- W1C write and edge set on the same edge: set wins; that flag reads 1 afterwards.
- Repeated edges while a flag is already set: flag stays 1, with no counting.
- Reset asserted mid-count: all state clears immediately. After release the debouncer restarts from IDLE with `level` = 0.

## Configuration
- `BUTTON_READER_IRQ_EN` defined:
  - CTRL register is implemented.
  - `irq` is driven as described above.
- `BUTTON_READER_IRQ_EN` undefined:
  - CTRL flops are not built; CTRL reads 0 and writes are ignored.
  - `irq` is tied to 0.
  - STATUS and PEND behave identically to the defined case.

## Structure
- Shared package `button_reader_pkg`:
  - register index constants `BR_STATUS` = 0, `BR_PEND` = 1, `BR_CTRL` = 2;
  - bit index constants `BR_RISE` = 0, `BR_FALL` = 1.
- One sub-module, `debounce`:
  - contains the synchroniser and the debouncer;
  - parameter DEBOUNCE_CYCLES;
  - outputs `level`, `rise_pulse`, `fall_pulse`.
- The top-level `button_reader` contains the register file, bus logic and `irq`.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 16.
- Reset sequence: hold `reset_n` = 0 for 3 cycles, then release → STATUS, PEND and CTRL read 0x0; `irq` = 0; `ready` pulses exactly once per read.
- Clean press: `btn_raw` 0→1 and held → `level` = 1 exactly 18 cycles later; PEND reads 0x1.
- Glitch: `btn_raw` high for 10 cycles, then low → STATUS stays 0x0 and PEND stays 0x0 throughout.
- Interrupt path (with `BUTTON_READER_IRQ_EN`):
  - write CTRL = 0x2, then press and release → `irq` rises 1 cycle after the falling-edge PEND bit sets;
  - write PEND = 0x2 → `irq` = 0 on the following cycle; PEND then reads 0x1 (RISE still set).
- Collision: issue a W1C write of PEND = 0x1 timed so it lands on the same edge as a new rise → PEND bit0 reads 1.
- Reset mid-count: assert `reset_n` 8 cycles into a press → `level` stays 0. After release, with `btn_raw` still held high, `level` = 1 exactly 18 cycles after release.
